// File: rtl/bird_physics_if.sv
// Bird physics control inputs (vsync, key level, restart) and sprite/state outputs.
// The master drives the inputs; the physics engine sits on the slave side.
interface bird_physics_if;
    logic        frame_vs;
    logic        press;
    logic        start;
    logic [10:0] BirdY;
    logic        flying;
    logic        dead;

    modport master (
        output frame_vs, press, start,
        input  BirdY, flying, dead
    );

    modport slave (
        input  frame_vs, press, start,
        output BirdY, flying, dead
    );
endinterface

// File: rtl/bird_physics.sv
// Per-frame gravity/flap integrator for the bird sprite, fixed-point 11.4 position.
// Latency: outputs update on the first Clk edge after the vsync falling-edge cycle.
// No backpressure: inputs are sampled every cycle and outputs are plain registers.
module bird_physics #(
    parameter int START_Y  = 240,
    parameter int FLOOR_Y  = 440,
    parameter int GRAVITY  = 6,
    parameter int FLAP_V   = 96,
    parameter int MAX_FALL = 128
) (
    input  logic          Clk,
    input  logic          Reset_n,
    bird_physics_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FLY, DEAD} state_t;

    localparam logic        [14:0] START_POS = 15'(START_Y * 16);
    localparam logic        [14:0] FLOOR_POS = 15'(FLOOR_Y * 16);
    localparam logic signed [15:0] FLOOR_CMP = 16'(FLOOR_Y * 16);
    localparam logic signed [10:0] GRAV_W    = 11'(GRAVITY);
    localparam logic signed [10:0] MAXF_W    = 11'(MAX_FALL);
    localparam logic signed [9:0]  MAXF_V    = 10'(MAX_FALL);
    localparam logic signed [9:0]  FLAP_NEG  = 10'(-FLAP_V);

    state_t             state, state_nxt;
    logic        [14:0] pos, pos_nxt;
    logic signed [9:0]  vel, vel_nxt;
    logic               flap_pending, pend_nxt;
    logic               press_q, vs_q;

    logic               frame_tick, flap_edge;
    logic signed [10:0] vel_sum;
    logic signed [9:0]  v_new;
    logic signed [15:0] p_new;

    assign frame_tick = vs_q & ~bus.frame_vs;
    assign flap_edge  = ~press_q & bus.press;

    // Gravity is added in 11 bits so the clamp sees the true sum before truncation.
    assign vel_sum = {vel[9], vel} + GRAV_W;
    assign v_new   = (flap_pending | flap_edge) ? FLAP_NEG
                   : (vel_sum > MAXF_W) ? MAXF_V : vel_sum[9:0];
    assign p_new   = $signed({1'b0, pos}) + $signed({{6{v_new[9]}}, v_new});

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        vel_nxt   = vel;
        pend_nxt  = flap_pending;
        case (state)
            IDLE: begin
                pos_nxt  = START_POS;
                vel_nxt  = '0;
                pend_nxt = 1'b0;
                if (!bus.start && flap_edge) begin
                    state_nxt = FLY;
                    pend_nxt  = 1'b1;
                end
            end
            FLY: begin
                if (bus.start) begin
                    state_nxt = IDLE;
                    pos_nxt   = START_POS;
                    vel_nxt   = '0;
                    pend_nxt  = 1'b0;
                end else if (frame_tick) begin
                    pend_nxt = 1'b0;
                    if (p_new < 0) begin
                        pos_nxt = '0;
                        vel_nxt = '0;
                    end else if (p_new >= FLOOR_CMP) begin
                        pos_nxt   = FLOOR_POS;
                        vel_nxt   = '0;
                        state_nxt = DEAD;
                    end else begin
                        pos_nxt = p_new[14:0];
                        vel_nxt = v_new;
                    end
                end else if (flap_edge) begin
                    pend_nxt = 1'b1;
                end
            end
            DEAD: begin
                if (bus.start) begin
                    state_nxt = IDLE;
                    pos_nxt   = START_POS;
                    vel_nxt   = '0;
                    pend_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // press_q resets high so a key already held at reset release is not a flap.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            pos          <= START_POS;
            vel          <= '0;
            flap_pending <= 1'b0;
            press_q      <= 1'b1;
            vs_q         <= 1'b1;
        end else begin
            state        <= state_nxt;
            pos          <= pos_nxt;
            vel          <= vel_nxt;
            flap_pending <= pend_nxt;
            press_q      <= bus.press;
            vs_q         <= bus.frame_vs;
        end
    end

    assign bus.BirdY  = pos[14:4];
    assign bus.flying = (state == FLY);
    assign bus.dead   = (state == DEAD);

endmodule

// File: tb/tb_bird_physics.sv
// Bird physics bench: directed plan scenarios plus randomized traffic against an integer model.
module tb_bird_physics;

    localparam int START_Y  = 240;
    localparam int FLOOR_Y  = 440;
    localparam int GRAVITY  = 6;
    localparam int FLAP_V   = 96;
    localparam int MAX_FALL = 128;

    localparam int M_IDLE = 0;
    localparam int M_FLY  = 1;
    localparam int M_DEAD = 2;

    logic Clk;
    logic Reset_n;
    bird_physics_if bus ();

    bird_physics #(
        .START_Y (START_Y),
        .FLOOR_Y (FLOOR_Y),
        .GRAVITY (GRAVITY),
        .FLAP_V  (FLAP_V),
        .MAX_FALL(MAX_FALL)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    int m_state, m_pos, m_vel;
    bit m_pend, m_vs_q, m_press_q;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_state   = M_IDLE;
        m_pos     = START_Y * 16;
        m_vel     = 0;
        m_pend    = 0;
        m_vs_q    = 1;
        m_press_q = 1;
    endtask

    // One clock of game physics expressed with plain integers.
    task automatic model_step(input bit vs, input bit pr, input bit st);
        bit tick, edge_p;
        int v, p;
        tick   = m_vs_q && !vs;
        edge_p = !m_press_q && pr;
        if (m_state == M_IDLE) begin
            if (!st && edge_p) begin
                m_state = M_FLY;
                m_pend  = 1;
            end
        end else if (st) begin
            m_state = M_IDLE;
            m_pos   = START_Y * 16;
            m_vel   = 0;
            m_pend  = 0;
        end else if (m_state == M_FLY) begin
            if (tick) begin
                if (m_pend || edge_p) v = -FLAP_V;
                else v = (m_vel + GRAVITY > MAX_FALL) ? MAX_FALL : m_vel + GRAVITY;
                p = m_pos + v;
                if (p < 0) begin
                    m_pos = 0;
                    m_vel = 0;
                end else if (p >= FLOOR_Y * 16) begin
                    m_pos   = FLOOR_Y * 16;
                    m_vel   = 0;
                    m_state = M_DEAD;
                end else begin
                    m_pos = p;
                    m_vel = v;
                end
                m_pend = 0;
            end else if (edge_p) begin
                m_pend = 1;
            end
        end
        m_vs_q    = vs;
        m_press_q = pr;
    endtask

    task automatic step(input logic vs, input logic pr, input logic st);
        bus.frame_vs = vs;
        bus.press    = pr;
        bus.start    = st;
        @(posedge Clk);
        model_step(vs, pr, st);
        @(negedge Clk);
        chk("birdy", int'(bus.BirdY), m_pos / 16);
        chk("flying", int'(bus.flying), int'(m_state == M_FLY));
        chk("dead", int'(bus.dead), int'(m_state == M_DEAD));
        chk("pos", int'(dut.pos), m_pos);
        chk("vel", int'(dut.vel), m_vel);
    endtask

    // vsync stays low for two cycles; only the first low cycle may update.
    task automatic frame(input logic pr);
        step(1'b1, pr, 1'b0);
        step(1'b1, pr, 1'b0);
        step(1'b0, pr, 1'b0);
        step(1'b0, pr, 1'b0);
    endtask

    task automatic flap_frame();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic vs_r, pr_r, st_r;

        Reset_n      = 1'b0;
        bus.frame_vs = 1'b1;
        bus.press    = 1'b0;
        bus.start    = 1'b0;
        model_reset();
        repeat (3) @(negedge Clk);
        chk("rst_birdy", int'(bus.BirdY), 240);
        chk("rst_flying", int'(bus.flying), 0);
        chk("rst_dead", int'(bus.dead), 0);
        Reset_n = 1'b1;

        repeat (3) frame(1'b0);
        chk("idle_birdy", int'(bus.BirdY), 240);
        chk("idle_flying", int'(bus.flying), 0);

        // First flap from IDLE, then one gravity frame.
        step(1'b1, 1'b1, 1'b0);
        chk("fly_enter", int'(bus.flying), 1);
        frame(1'b1);
        chk("f1_vel", int'(dut.vel), -96);
        chk("f1_pos", int'(dut.pos), 3744);
        chk("f1_birdy", int'(bus.BirdY), 234);
        frame(1'b1);
        chk("f2_vel", int'(dut.vel), -90);
        chk("f2_pos", int'(dut.pos), 3654);
        chk("f2_birdy", int'(bus.BirdY), 228);

        // Flap into the ceiling.
        repeat (50) flap_frame();
        chk("ceil_birdy", int'(bus.BirdY), 0);
        chk("ceil_vel", int'(dut.vel), 0);

        // Free fall from rest up to terminal velocity.
        for (int k = 1; k <= 25; k++) begin
            frame(1'b0);
            chk("term_vel", int'(dut.vel), (k * 6 > 128) ? 128 : k * 6);
        end

        // Press edge in the same cycle as the vsync edge.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("same_cycle_vel", int'(dut.vel), -96);
        step(1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 300 && !bus.dead; i++) frame(1'b0);
        chk("floor_dead", int'(bus.dead), 1);
        chk("floor_birdy", int'(bus.BirdY), 440);
        repeat (3) flap_frame();
        chk("dead_frozen", int'(bus.BirdY), 440);
        chk("dead_hold", int'(bus.dead), 1);

        step(1'b1, 1'b0, 1'b1);
        chk("restart_birdy", int'(bus.BirdY), 240);
        chk("restart_flying", int'(bus.flying), 0);

        // start and flap edge together: stay in IDLE.
        step(1'b1, 1'b1, 1'b1);
        chk("start_flap_flying", int'(bus.flying), 0);
        chk("start_flap_birdy", int'(bus.BirdY), 240);
        step(1'b1, 1'b0, 1'b0);

        // start and frame tick together in FLY: back to IDLE, no motion.
        step(1'b1, 1'b1, 1'b0);
        frame(1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("start_tick_birdy", int'(bus.BirdY), 240);
        chk("start_tick_flying", int'(bus.flying), 0);

        // Asynchronous reset between clock edges while flying.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        frame(1'b1);
        frame(1'b1);
        chk("pre_arst_flying", int'(bus.flying), 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_birdy", int'(bus.BirdY), 240);
        chk("arst_flying", int'(bus.flying), 0);
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);

        // Randomized traffic.
        pr_r = bus.press;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) pr_r = ~pr_r;
            st_r = ($urandom_range(0, 99) == 0);
            vs_r = ($urandom_range(0, 9) != 0);
            step(vs_r, pr_r, st_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
